if_fetch_stage: RTL and testbench

- Instruction-fetch stage with PC register, single-outstanding instruction-memory request FSM, and IF/ID pipeline register.
- Sits directly upstream of the hazard detection unit. It consumes pc_hold, ifid_hold and if_flush, plus the ID-stage beq redirect.
- It produces the IF/ID opcode/rs/rt fields the hazard unit compares against.

---
 rtl/if_fetch_stage_if.sv | 11 +
 rtl/if_fetch_stage.sv | 151 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus: the fetch stage holds req/addr until rvalid, and rvalid may rise in the request cycle.
`timescale 1ns/1ps
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, one outstanding imem request, IF/ID register; 1 instr/cycle with zero-wait memory.
// Backpressure from pc_hold/ifid_hold parks an accepted word in a one-entry skid buffer.
`timescale 1ns/1ps
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_hold,
  input  logic              ifid_hold,
  input  logic              if_flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  if_fetch_stage_if.master  imem,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc_plus4,
  output logic [5:0]        ifid_opcode,
  output logic [4:0]        ifid_rs,
  output logic [4:0]        ifid_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD_DATA, DISCARD} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [31:0]        skid_q, skid_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [31:0]        pc_inc;
  logic               redirect;

  assign pc_inc   = pc_q + 32'd4;
  assign redirect = branch_taken && !ifid_hold;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    skid_d        = skid_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    pc4_d         = pc4_q;
    imem.imem_req = 1'b0;
    // IF/ID bubbles by default unless the hazard unit is holding it
    if (!ifid_hold) begin
      valid_d = 1'b0;
      instr_d = 32'h0;
    end

    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        req_addr_d = pc_q;
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_rvalid) begin
          if (redirect) begin
            pc_d       = branch_target;
            req_addr_d = branch_target;
          end else if (ifid_hold || pc_hold) begin
            skid_d  = imem.imem_rdata;
            state_d = HOLD_DATA;
          end else if (!if_flush) begin
            valid_d    = 1'b1;
            instr_d    = imem.imem_rdata;
            pc4_d      = pc_inc;
            pc_d       = pc_inc;
            req_addr_d = pc_inc;
          end
        end else if (redirect) begin
          pc_d    = branch_target;
          state_d = DISCARD;
        end
      end
      HOLD_DATA: begin
        if (ifid_hold || pc_hold) begin
          valid_d = valid_q;
          instr_d = instr_q;
        end else begin
          state_d = FETCH;
          if (branch_taken) begin
            pc_d       = branch_target;
            req_addr_d = branch_target;
          end else if (if_flush) begin
            req_addr_d = pc_q;
          end else begin
            valid_d    = 1'b1;
            instr_d    = skid_q;
            pc4_d      = pc_inc;
            pc_d       = pc_inc;
            req_addr_d = pc_inc;
          end
        end
      end
      DISCARD: begin
        // stale request must complete before the redirected fetch can issue
        imem.imem_req = 1'b1;
        if (branch_taken) pc_d = branch_target;
        if (imem.imem_rvalid) begin
          req_addr_d = branch_taken ? branch_target : pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (ifid_hold && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= PC_RESET;
      req_addr_q <= PC_RESET;
      skid_q     <= 32'h0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      pc4_q      <= 32'h0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      skid_q     <= skid_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      stall_q    <= stall_d;
    end
  end

  assign imem.imem_addr = req_addr_q;
  assign ifid_valid     = valid_q;
  assign ifid_instr     = instr_q;
  assign ifid_pc_plus4  = pc4_q;
  assign ifid_opcode    = instr_q[31:26];
  assign ifid_rs        = instr_q[25:21];
  assign ifid_rt        = instr_q[20:16];
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed cycle table, corner sequences, then random hazards vs a reference model.
`timescale 1ns/1ps
module tb_if_fetch_stage;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_hold = 1'b0, ifid_hold = 1'b0, if_flush = 1'b0, branch_taken = 1'b0;
  logic [31:0]   branch_target = 32'h0;
  logic          ifid_valid;
  logic [31:0]   ifid_instr, ifid_pc_plus4;
  logic [5:0]    ifid_opcode;
  logic [4:0]    ifid_rs, ifid_rt;
  logic [CW-1:0] stall_cnt;

  if_fetch_stage_if bus();

  if_fetch_stage #(.PC_RESET(32'h0000_0000), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .if_flush(if_flush),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem(bus),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_vld, input logic [31:0] e_instr, input logic [31:0] e_pc4,
                            input logic [31:0] e_st);
    check({tag, ".req"},    {31'b0, bus.imem_req}, {31'b0, e_req});
    check({tag, ".addr"},   bus.imem_addr, e_addr);
    check({tag, ".valid"},  {31'b0, ifid_valid}, {31'b0, e_vld});
    check({tag, ".instr"},  ifid_instr, e_instr);
    check({tag, ".pc4"},    ifid_pc_plus4, e_pc4);
    check({tag, ".opcode"}, {26'b0, ifid_opcode}, e_instr >> 26);
    check({tag, ".rs"},     {27'b0, ifid_rs}, (e_instr >> 21) & 32'h1F);
    check({tag, ".rt"},     {27'b0, ifid_rt}, (e_instr >> 16) & 32'h1F);
    check({tag, ".stall"},  {{(32-CW){1'b0}}, stall_cnt}, e_st);
  endtask

  task automatic drive(input logic ph, input logic ih, input logic fl, input logic br,
                       input logic [31:0] tgt, input logic rv, input logic [31:0] rd);
    pc_hold = ph; ifid_hold = ih; if_flush = fl; branch_taken = br; branch_target = tgt;
    bus.imem_rvalid = rv; bus.imem_rdata = rd;
  endtask

  // one row = inputs for a cycle and the outputs expected just after that edge
  typedef struct packed {
    logic ph, ih, fl, br; logic [31:0] tgt; logic rv; logic [31:0] rd;
    logic e_req; logic [31:0] e_addr; logic e_vld; logic [31:0] e_instr, e_pc4, e_st;
  } vec_t;

  function automatic vec_t mk(input logic ph, ih, fl, br, input logic [31:0] tgt, input logic rv,
                              input logic [31:0] rd, input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_instr, e_pc4, e_st);
    mk = {ph, ih, fl, br, tgt, rv, rd, e_req, e_addr, e_vld, e_instr, e_pc4, e_st};
  endfunction

  vec_t tbl[25];

  // reference model: transaction-level view of the fetch stage
  logic        m_started, m_have_buf, m_drop, m_vld;
  logic [31:0] m_pc, m_addr, m_buf, m_instr, m_pc4;
  int          m_stall;

  task automatic model_reset();
    m_started = 0; m_have_buf = 0; m_drop = 0; m_vld = 0;
    m_pc = 0; m_addr = 0; m_buf = 0; m_instr = 0; m_pc4 = 0; m_stall = 0;
  endtask

  function automatic logic model_req();
    return m_started && !m_have_buf;
  endfunction

  task automatic bubble_unless(input logic ih);
    if (!ih) begin m_vld = 0; m_instr = 0; end
  endtask

  task automatic model_step(input logic ph, ih, fl, br, input logic [31:0] tgt, input logic rv,
                            input logic [31:0] rd);
    if (ih && m_stall < (1 << CW) - 1) m_stall++;
    if (!m_started) begin
      m_started = 1; m_addr = m_pc; bubble_unless(ih);
    end else if (m_have_buf) begin
      if (!(ih || ph)) begin
        if (br) begin m_pc = tgt; m_vld = 0; m_instr = 0; end
        else if (fl) begin m_vld = 0; m_instr = 0; end
        else begin m_instr = m_buf; m_vld = 1; m_pc4 = m_pc + 4; m_pc = m_pc + 4; end
        m_have_buf = 0; m_addr = m_pc;
      end
    end else if (m_drop) begin
      if (br) m_pc = tgt;
      bubble_unless(ih);
      if (rv) begin m_drop = 0; m_addr = m_pc; end
    end else if (rv) begin
      if (br && !ih) begin m_pc = tgt; m_addr = tgt; m_vld = 0; m_instr = 0; end
      else if (ih || ph) begin m_buf = rd; m_have_buf = 1; bubble_unless(ih); end
      else if (fl) begin m_vld = 0; m_instr = 0; end
      else begin m_instr = rd; m_vld = 1; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_addr = m_pc; end
    end else begin
      if (br && !ih) begin m_pc = tgt; m_drop = 1; m_vld = 0; m_instr = 0; end
      else bubble_unless(ih);
    end
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,0, 0,     0, 0,            1, 32'h0,        0, 0,            0,     0);
    tbl[1]  = mk(0,0,0,0, 0,     1, 32'h0,        1, 32'h4,        1, 32'h0,        32'h4, 0);
    tbl[2]  = mk(0,0,0,0, 0,     1, 32'h4,        1, 32'h8,        1, 32'h4,        32'h8, 0);
    tbl[3]  = mk(0,0,0,0, 0,     1, 32'h8,        1, 32'hC,        1, 32'h8,        32'hC, 0);
    tbl[4]  = mk(0,0,0,0, 0,     1, 32'h8C0A0000, 1, 32'h10,       1, 32'h8C0A0000, 32'h10, 0);
    tbl[5]  = mk(1,1,1,0, 0,     1, 32'h11111111, 0, 32'h10,       1, 32'h8C0A0000, 32'h10, 1);
    tbl[6]  = mk(1,1,1,0, 0,     0, 0,            0, 32'h10,       1, 32'h8C0A0000, 32'h10, 2);
    tbl[7]  = mk(0,0,0,0, 0,     0, 0,            1, 32'h14,       1, 32'h11111111, 32'h14, 2);
    tbl[8]  = mk(0,0,0,0, 0,     1, 32'h14,       1, 32'h18,       1, 32'h14,       32'h18, 2);
    tbl[9]  = mk(0,0,1,0, 0,     1, 32'h18,       1, 32'h18,       0, 0,            32'h18, 2);
    tbl[10] = mk(0,0,0,0, 0,     1, 32'h18,       1, 32'h1C,       1, 32'h18,       32'h1C, 2);
    tbl[11] = mk(0,0,0,0, 0,     1, 32'h1C,       1, 32'h20,       1, 32'h1C,       32'h20, 2);
    tbl[12] = mk(0,0,0,1, 32'h80, 0, 0,           1, 32'h20,       0, 0,            32'h20, 2);
    tbl[13] = mk(0,0,0,0, 0,     0, 0,            1, 32'h20,       0, 0,            32'h20, 2);
    tbl[14] = mk(0,0,0,0, 0,     1, 32'hDEAD,     1, 32'h80,       0, 0,            32'h20, 2);
    tbl[15] = mk(0,0,0,0, 0,     1, 32'h80,       1, 32'h84,       1, 32'h80,       32'h84, 2);
    tbl[16] = mk(0,0,0,1, 32'hFFFFFFFC, 1, 32'hBAD, 1, 32'hFFFFFFFC, 0, 0,          32'h84, 2);
    tbl[17] = mk(0,0,0,0, 0,     1, 32'hABCD,     1, 32'h0,        1, 32'hABCD,     32'h0, 2);
    tbl[18] = mk(0,1,0,0, 0,     0, 0,            1, 32'h0,        1, 32'hABCD,     32'h0, 3);
    tbl[19] = mk(0,1,0,1, 32'h100, 1, 32'h5,      0, 32'h0,        1, 32'hABCD,     32'h0, 4);
    tbl[20] = mk(1,0,0,1, 32'h200, 0, 0,          0, 32'h0,        1, 32'hABCD,     32'h0, 4);
    tbl[21] = mk(0,0,0,1, 32'h300, 0, 0,          1, 32'h300,      0, 0,            32'h0, 4);
    tbl[22] = mk(0,0,0,0, 0,     1, 32'h77,       1, 32'h304,      1, 32'h77,       32'h304, 4);
    tbl[23] = mk(0,0,0,0, 0,     0, 0,            1, 32'h304,      0, 0,            32'h304, 4);
    tbl[24] = mk(0,0,0,0, 0,     1, 32'h88,       1, 32'h308,      1, 32'h88,       32'h308, 4);

    drive(0,0,0,0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check_outs("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].ph, tbl[i].ih, tbl[i].fl, tbl[i].br, tbl[i].tgt, tbl[i].rv, tbl[i].rd);
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                 tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_st);
    end

    // stall counter saturation with IF/ID frozen
    drive(0,1,0,0, 0, 0, 0);
    repeat (11) @(posedge clk);
    #1 check_outs("sat15", 1, 32'h308, 1, 32'h88, 32'h308, 15);
    repeat (3) @(posedge clk);
    #1 check_outs("sat_hold", 1, 32'h308, 1, 32'h88, 32'h308, 15);

    // reset asserted while a stale request is outstanding
    drive(0,0,0,1, 32'h500, 0, 0);
    @(posedge clk); #1 check_outs("discard", 1, 32'h308, 0, 32'h0, 32'h308, 15);
    drive(0,0,0,0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_outs("rst_async", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check_outs("restart", 1, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(0,0,0,0, 0, 1, 32'h1234);
    @(posedge clk); #1 check_outs("restart_acc", 1, 32'h4, 1, 32'h1234, 32'h4, 0);

    // randomized hazards and memory latency against the model
    drive(0,0,0,0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    begin
      int age = 0;
      int lat = 0;
      for (int c = 0; c < 3000; c++) begin
        logic ph, ih, fl, br, rv, rq;
        logic [31:0] tgt, rd;
        ph  = ($urandom_range(0, 5) == 0);
        ih  = ($urandom_range(0, 5) == 0);
        fl  = ($urandom_range(0, 7) == 0);
        br  = ($urandom_range(0, 7) == 0);
        tgt = $urandom & 32'hFFFF_FFFC;
        rd  = $urandom;
        rq  = model_req();
        rv  = rq && (age >= lat);
        drive(ph, ih, fl, br, tgt, rv, rd);
        @(posedge clk);
        model_step(ph, ih, fl, br, tgt, rv, rd);
        if (rq && !rv) age++;
        else begin
          age = 0;
          if (rv) lat = $urandom_range(0, 3);
        end
        #1 check_outs($sformatf("rnd%0d", c), model_req(), m_addr, m_vld, m_instr, m_pc4, m_stall);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
